// File: rtl/vin_gen_pkg.sv
// Shared types and constants for the VIN-side master of the VIN<->GEN bus.
// Defines the sequencer states, bus cycle types, default strobe timing and the valid row limit.
package vin_gen_pkg;

    typedef enum logic [3:0] {
        IDLE,
        T1_SU, T1_ST, T1_HD,
        T2_SU, T2_ST, T2_HD,
        T3_SU, T3_ST, T3_HD,
        T4_SU, T4_ST, T4_HD
    } state_e;

    typedef enum logic [1:0] {
        PH_SU,
        PH_ST,
        PH_HD,
        PH_NONE
    } phase_e;

    localparam logic [1:0] CYC_T1 = 2'd0;
    localparam logic [1:0] CYC_T2 = 2'd1;
    localparam logic [1:0] CYC_T3 = 2'd2;
    localparam logic [1:0] CYC_T4 = 2'd3;

    localparam int DEF_SETUP_CYC  = 1;
    localparam int DEF_STROBE_CYC = 4;
    localparam int DEF_HOLD_CYC   = 1;

    localparam logic [3:0] MAX_ROW = 4'd9;

    // IDLE maps to CYC_T1; callers must qualify with "state != IDLE".
    function automatic logic [1:0] state_cyc(input state_e s);
        logic [1:0] c;
        case (s)
            T2_SU, T2_ST, T2_HD: c = CYC_T2;
            T3_SU, T3_ST, T3_HD: c = CYC_T3;
            T4_SU, T4_ST, T4_HD: c = CYC_T4;
            default:             c = CYC_T1;
        endcase
        return c;
    endfunction

    function automatic phase_e state_phase(input state_e s);
        phase_e p;
        case (s)
            T1_SU, T2_SU, T3_SU, T4_SU: p = PH_SU;
            T1_ST, T2_ST, T3_ST, T4_ST: p = PH_ST;
            T1_HD, T2_HD, T3_HD, T4_HD: p = PH_HD;
            default:                    p = PH_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vin_gen_phase_timer.sv
// Loadable 4-bit down-counter shared by every bus phase.
// Load with (phase length - 1); "last" is high during the final clock of the phase.
module vin_gen_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       last
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == 4'd0);

endmodule

// File: rtl/vin_gen_bus_master.sv
// VIN-side bus master: turns character-slice requests into TYPE1+TYPE2 cycles and
// mailbox requests into TYPE3/TYPE4 cycles toward the EF9341 GEN. All outputs are registered.
module vin_gen_bus_master
    import vin_gen_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_req,
    input  logic [7:0] char_a,
    input  logic [7:0] char_b,
    input  logic [3:0] char_row,
    output logic       char_ack,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    input  logic       mbx_rd_req,
    input  logic       mbx_wr_req,
    input  logic [7:0] mbx_wdata_a,
    input  logic [7:0] mbx_wdata_b,
    output logic [7:0] mbx_rdata_a,
    output logic [7:0] mbx_rdata_b,
    output logic       mbx_ack,
    input  logic       ve_n,
    output logic       mbx_pending,
    output logic       busy,
    output logic       sm_n,
    output logic       sg_n,
    output logic       st_n,
    output logic       r_wi,
    output logic [3:0] adr,
    output logic [7:0] busA_o,
    output logic [7:0] busB_o,
    output logic       bus_oe,
    input  logic [7:0] busA_i,
    input  logic [7:0] busB_i
);

    localparam logic [3:0] SU_LEN = 4'(SETUP_CYC - 1);
    localparam logic [3:0] ST_LEN = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HD_LEN = 4'(HOLD_CYC - 1);

    state_e     state_q, state_d;
    logic       timer_load, timer_last;
    logic [3:0] timer_val;
    logic       accept_char, accept_rd, accept_wr;

    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic [3:0] row_q, row_d;
    logic [7:0] samp_q, samp_d;

    logic       sm_n_q, sm_n_d;
    logic       sg_n_q, sg_n_d;
    logic       st_n_q, st_n_d;
    logic       r_wi_q, r_wi_d;
    logic       bus_oe_q, bus_oe_d;
    logic [3:0] adr_q, adr_d;
    logic [7:0] busA_o_q, busA_o_d;
    logic [7:0] busB_o_q, busB_o_d;
    logic       busy_q, busy_d;
    logic       char_ack_q, char_ack_d;
    logic       pix_valid_q, pix_valid_d;
    logic [7:0] pix_data_q, pix_data_d;
    logic       mbx_ack_q, mbx_ack_d;
    logic [7:0] mbx_rdata_a_q, mbx_rdata_a_d;
    logic [7:0] mbx_rdata_b_q, mbx_rdata_b_d;
    logic       mbx_pending_q, mbx_pending_d;

    logic       active_d;
    logic [1:0] cyc_d;
    phase_e     ph_d;

    vin_gen_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .last     (timer_last)
    );

    // Arbitration happens only in IDLE; every other state advances when its phase timer expires.
    always_comb begin
        state_d     = state_q;
        accept_char = 1'b0;
        accept_rd   = 1'b0;
        accept_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (char_req) begin
                    state_d     = T1_SU;
                    accept_char = 1'b1;
                end else if (mbx_rd_req) begin
                    state_d   = T3_SU;
                    accept_rd = 1'b1;
                end else if (mbx_wr_req) begin
                    state_d   = T4_SU;
                    accept_wr = 1'b1;
                end
            end
            T1_SU: if (timer_last) state_d = T1_ST;
            T1_ST: if (timer_last) state_d = T1_HD;
            T1_HD: if (timer_last) state_d = T2_SU;
            T2_SU: if (timer_last) state_d = T2_ST;
            T2_ST: if (timer_last) state_d = T2_HD;
            T2_HD: if (timer_last) state_d = IDLE;
            T3_SU: if (timer_last) state_d = T3_ST;
            T3_ST: if (timer_last) state_d = T3_HD;
            T3_HD: if (timer_last) state_d = IDLE;
            T4_SU: if (timer_last) state_d = T4_ST;
            T4_ST: if (timer_last) state_d = T4_HD;
            T4_HD: if (timer_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        active_d   = (state_d != IDLE);
        cyc_d      = state_cyc(state_d);
        ph_d       = state_phase(state_d);
        timer_load = (state_d != state_q);
        case (ph_d)
            PH_SU:   timer_val = SU_LEN;
            PH_ST:   timer_val = ST_LEN;
            PH_HD:   timer_val = HD_LEN;
            default: timer_val = 4'd0;
        endcase
    end

    // Strobes and bus drive are decoded from the next state so they appear registered
    // in exactly the clocks the state occupies.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        row_d  = row_q;
        if (accept_char) begin
            op_a_d = char_a;
            op_b_d = char_b;
            row_d  = char_row;
        end else if (accept_wr) begin
            op_a_d = mbx_wdata_a;
            op_b_d = mbx_wdata_b;
        end

        sm_n_d   = !(active_d && ph_d == PH_ST && (cyc_d == CYC_T1 || cyc_d == CYC_T4));
        sg_n_d   = !(active_d && ph_d == PH_ST && cyc_d == CYC_T2);
        st_n_d   = !(active_d && ((cyc_d == CYC_T3 && ph_d == PH_ST) || cyc_d == CYC_T4));
        r_wi_d   = !(active_d && cyc_d == CYC_T3);
        bus_oe_d = active_d && (cyc_d == CYC_T1 || cyc_d == CYC_T4);
        busy_d   = active_d;

        busA_o_d = busA_o_q;
        busB_o_d = busB_o_q;
        if (bus_oe_d) begin
            busA_o_d = op_a_d;
            busB_o_d = op_b_d;
        end
        adr_d = adr_q;
        if (active_d && cyc_d == CYC_T2) begin
            adr_d = row_d;
        end
    end

    // Read data is captured on the final strobe-low clock, when the GEN output is settled.
    always_comb begin
        samp_d        = samp_q;
        mbx_rdata_a_d = mbx_rdata_a_q;
        mbx_rdata_b_d = mbx_rdata_b_q;
        pix_data_d    = pix_data_q;
        char_ack_d    = accept_char;
        pix_valid_d   = (state_q == T2_HD) && timer_last;
        mbx_ack_d     = ((state_q == T3_HD) || (state_q == T4_HD)) && timer_last;
        mbx_pending_d = ~ve_n;

        if (state_q == T2_ST && timer_last) begin
            samp_d = busA_i;
        end
        if (state_q == T3_ST && timer_last) begin
            mbx_rdata_a_d = busA_i;
            mbx_rdata_b_d = busB_i;
        end
        if (pix_valid_d) begin
            pix_data_d = (row_q > MAX_ROW) ? 8'h00 : samp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_a_q        <= 8'h00;
            op_b_q        <= 8'h00;
            row_q         <= 4'd0;
            samp_q        <= 8'h00;
            sm_n_q        <= 1'b1;
            sg_n_q        <= 1'b1;
            st_n_q        <= 1'b1;
            r_wi_q        <= 1'b1;
            bus_oe_q      <= 1'b0;
            adr_q         <= 4'd0;
            busA_o_q      <= 8'h00;
            busB_o_q      <= 8'h00;
            busy_q        <= 1'b0;
            char_ack_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= 8'h00;
            mbx_ack_q     <= 1'b0;
            mbx_rdata_a_q <= 8'h00;
            mbx_rdata_b_q <= 8'h00;
            mbx_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            row_q         <= row_d;
            samp_q        <= samp_d;
            sm_n_q        <= sm_n_d;
            sg_n_q        <= sg_n_d;
            st_n_q        <= st_n_d;
            r_wi_q        <= r_wi_d;
            bus_oe_q      <= bus_oe_d;
            adr_q         <= adr_d;
            busA_o_q      <= busA_o_d;
            busB_o_q      <= busB_o_d;
            busy_q        <= busy_d;
            char_ack_q    <= char_ack_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            mbx_ack_q     <= mbx_ack_d;
            mbx_rdata_a_q <= mbx_rdata_a_d;
            mbx_rdata_b_q <= mbx_rdata_b_d;
            mbx_pending_q <= mbx_pending_d;
        end
    end

    assign sm_n        = sm_n_q;
    assign sg_n        = sg_n_q;
    assign st_n        = st_n_q;
    assign r_wi        = r_wi_q;
    assign bus_oe      = bus_oe_q;
    assign adr         = adr_q;
    assign busA_o      = busA_o_q;
    assign busB_o      = busB_o_q;
    assign busy        = busy_q;
    assign char_ack    = char_ack_q;
    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign mbx_ack     = mbx_ack_q;
    assign mbx_rdata_a = mbx_rdata_a_q;
    assign mbx_rdata_b = mbx_rdata_b_q;
    assign mbx_pending = mbx_pending_q;

endmodule

// File: tb/tb_vin_gen_bus_master.sv
// Bench for vin_gen_bus_master: a default-timing and a 2/3/2-timing instance share one GEN model;
// expected strobe windows come from per-transaction clock offsets relative to the accept edge.
module tb_vin_gen_bus_master;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] row;
        logic [7:0] pix;
        logic [7:0] expPix;
    } charVec_t;

    logic clk;
    logic rst;
    logic sel;
    logic char_req, mbx_rd_req, mbx_wr_req, ve_n;
    logic [7:0] char_a, char_b, mbx_wdata_a, mbx_wdata_b;
    logic [3:0] char_row;
    logic [7:0] gen_pix, gen_ta, gen_tb;

    logic [1:0] char_req_w, rd_req_w, wr_req_w;
    logic [1:0] char_ack_w, pix_valid_w, mbx_ack_w, mbx_pending_w, busy_w;
    logic [1:0] sm_n_w, sg_n_w, st_n_w, r_wi_w, bus_oe_w;
    logic [1:0][7:0] pix_data_w, rdata_a_w, rdata_b_w, busA_o_w, busB_o_w, busA_i_w, busB_i_w;
    logic [1:0][3:0] adr_w;

    int nCompared = 0;
    int nFailed   = 0;
    int S = 1, T = 4, H = 1, L = 6;
    charVec_t vecs[6];

    vin_gen_bus_master dut0 (
        .clk(clk), .rst(rst),
        .char_req(char_req_w[0]), .char_a(char_a), .char_b(char_b), .char_row(char_row),
        .char_ack(char_ack_w[0]), .pix_data(pix_data_w[0]), .pix_valid(pix_valid_w[0]),
        .mbx_rd_req(rd_req_w[0]), .mbx_wr_req(wr_req_w[0]),
        .mbx_wdata_a(mbx_wdata_a), .mbx_wdata_b(mbx_wdata_b),
        .mbx_rdata_a(rdata_a_w[0]), .mbx_rdata_b(rdata_b_w[0]), .mbx_ack(mbx_ack_w[0]),
        .ve_n(ve_n), .mbx_pending(mbx_pending_w[0]), .busy(busy_w[0]),
        .sm_n(sm_n_w[0]), .sg_n(sg_n_w[0]), .st_n(st_n_w[0]), .r_wi(r_wi_w[0]), .adr(adr_w[0]),
        .busA_o(busA_o_w[0]), .busB_o(busB_o_w[0]), .bus_oe(bus_oe_w[0]),
        .busA_i(busA_i_w[0]), .busB_i(busB_i_w[0])
    );

    vin_gen_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut1 (
        .clk(clk), .rst(rst),
        .char_req(char_req_w[1]), .char_a(char_a), .char_b(char_b), .char_row(char_row),
        .char_ack(char_ack_w[1]), .pix_data(pix_data_w[1]), .pix_valid(pix_valid_w[1]),
        .mbx_rd_req(rd_req_w[1]), .mbx_wr_req(wr_req_w[1]),
        .mbx_wdata_a(mbx_wdata_a), .mbx_wdata_b(mbx_wdata_b),
        .mbx_rdata_a(rdata_a_w[1]), .mbx_rdata_b(rdata_b_w[1]), .mbx_ack(mbx_ack_w[1]),
        .ve_n(ve_n), .mbx_pending(mbx_pending_w[1]), .busy(busy_w[1]),
        .sm_n(sm_n_w[1]), .sg_n(sg_n_w[1]), .st_n(st_n_w[1]), .r_wi(r_wi_w[1]), .adr(adr_w[1]),
        .busA_o(busA_o_w[1]), .busB_o(busB_o_w[1]), .bus_oe(bus_oe_w[1]),
        .busA_i(busA_i_w[1]), .busB_i(busB_i_w[1])
    );

    // GEN model: pixel slice while sg_n is low, TA/TB while a TYPE3 st_n is low, filler otherwise.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            char_req_w[i] = char_req && (sel == i[0]);
            rd_req_w[i]   = mbx_rd_req && (sel == i[0]);
            wr_req_w[i]   = mbx_wr_req && (sel == i[0]);
            busA_i_w[i]   = 8'hEE;
            busB_i_w[i]   = 8'hEE;
            if (!sg_n_w[i]) begin
                busA_i_w[i] = gen_pix;
            end else if (!st_n_w[i] && !r_wi_w[i]) begin
                busA_i_w[i] = gen_ta;
                busB_i_w[i] = gen_tb;
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] refPix(input logic [3:0] row, input logic [7:0] pix);
        return (row > 4'd9) ? 8'h00 : pix;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic setTiming(input logic s, input int su, input int st, input int hd);
        sel = s;
        S = su;
        T = st;
        H = hd;
        L = su + st + hd;
    endtask

    task automatic applyStimulus(input int kind, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] row);
        case (kind)
            0: begin char_a = a; char_b = b; char_row = row; char_req = 1'b1; end
            1: mbx_rd_req = 1'b1;
            default: begin mbx_wdata_a = a; mbx_wdata_b = b; mbx_wr_req = 1'b1; end
        endcase
    endtask

    task automatic runChar(input logic [7:0] a, input logic [7:0] b, input logic [3:0] row,
                           input logic [7:0] pix, input logic [7:0] expPix);
        gen_pix = pix;
        applyStimulus(0, a, b, row);
        for (int k = 1; k <= 2 * L + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("char_ack k%0d", k), 32'(sel ? char_ack_w[1] : char_ack_w[0]), 32'(k == 1));
            checkOutput($sformatf("pix_valid k%0d", k), 32'(pix_valid_w[sel]), 32'(k == 2 * L + 1));
            checkOutput($sformatf("busy k%0d", k), 32'(busy_w[sel]), 32'(k <= 2 * L));
            checkOutput($sformatf("sm_n k%0d", k), 32'(sm_n_w[sel]), 32'(!(k > S && k <= S + T)));
            checkOutput($sformatf("sg_n k%0d", k), 32'(sg_n_w[sel]), 32'(!(k > L + S && k <= L + S + T)));
            checkOutput($sformatf("st_n k%0d", k), 32'(st_n_w[sel]), 32'(1));
            checkOutput($sformatf("r_wi k%0d", k), 32'(r_wi_w[sel]), 32'(1));
            checkOutput($sformatf("bus_oe k%0d", k), 32'(bus_oe_w[sel]), 32'(k <= L));
            checkOutput($sformatf("mbx_ack k%0d", k), 32'(mbx_ack_w[sel]), 32'(0));
            if (k <= L) begin
                checkOutput($sformatf("busA_o k%0d", k), 32'(busA_o_w[sel]), 32'(a));
                checkOutput($sformatf("busB_o k%0d", k), 32'(busB_o_w[sel]), 32'(b));
            end else if (k <= 2 * L) begin
                checkOutput($sformatf("adr k%0d", k), 32'(adr_w[sel]), 32'(row));
            end else begin
                checkOutput("pix_data", 32'(pix_data_w[sel]), 32'(expPix));
            end
            if (k == 1) char_req = 1'b0;
        end
    endtask

    task automatic runRd(input logic [7:0] ta, input logic [7:0] tb);
        gen_ta = ta;
        gen_tb = tb;
        applyStimulus(1, 8'h00, 8'h00, 4'd0);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rd st_n k%0d", k), 32'(st_n_w[sel]), 32'(!(k > S && k <= S + T)));
            checkOutput($sformatf("rd r_wi k%0d", k), 32'(r_wi_w[sel]), 32'(!(k <= L)));
            checkOutput($sformatf("rd sm_n k%0d", k), 32'(sm_n_w[sel]), 32'(1));
            checkOutput($sformatf("rd sg_n k%0d", k), 32'(sg_n_w[sel]), 32'(1));
            checkOutput($sformatf("rd bus_oe k%0d", k), 32'(bus_oe_w[sel]), 32'(0));
            checkOutput($sformatf("rd busy k%0d", k), 32'(busy_w[sel]), 32'(k <= L));
            checkOutput($sformatf("rd mbx_ack k%0d", k), 32'(mbx_ack_w[sel]), 32'(k == L + 1));
            checkOutput($sformatf("rd char_ack k%0d", k), 32'(char_ack_w[sel]), 32'(0));
            if (k == L + 1) begin
                checkOutput("mbx_rdata_a", 32'(rdata_a_w[sel]), 32'(ta));
                checkOutput("mbx_rdata_b", 32'(rdata_b_w[sel]), 32'(tb));
            end
            if (k == 1) mbx_rd_req = 1'b0;
        end
    endtask

    task automatic runWr(input logic [7:0] wa, input logic [7:0] wb);
        logic [7:0] latA, latB;
        latA = 8'h00;
        latB = 8'h00;
        applyStimulus(2, wa, wb, 4'd0);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("wr st_n k%0d", k), 32'(st_n_w[sel]), 32'(!(k <= L)));
            checkOutput($sformatf("wr sm_n k%0d", k), 32'(sm_n_w[sel]), 32'(!(k > S && k <= S + T)));
            checkOutput($sformatf("wr sg_n k%0d", k), 32'(sg_n_w[sel]), 32'(1));
            checkOutput($sformatf("wr r_wi k%0d", k), 32'(r_wi_w[sel]), 32'(1));
            checkOutput($sformatf("wr bus_oe k%0d", k), 32'(bus_oe_w[sel]), 32'(k <= L));
            checkOutput($sformatf("wr busy k%0d", k), 32'(busy_w[sel]), 32'(k <= L));
            checkOutput($sformatf("wr mbx_ack k%0d", k), 32'(mbx_ack_w[sel]), 32'(k == L + 1));
            if (!sm_n_w[sel] && !st_n_w[sel]) begin
                latA = busA_o_w[sel];
                latB = busB_o_w[sel];
            end
            if (k == 1) mbx_wr_req = 1'b0;
        end
        checkOutput("gen latched TA", 32'(latA), 32'(wa));
        checkOutput("gen latched TB", 32'(latB), 32'(wb));
    endtask

    initial begin
        vecs[0] = '{a: 8'h00, b: 8'h41, row: 4'd3,  pix: 8'h3C, expPix: 8'h3C};
        vecs[1] = '{a: 8'h80, b: 8'h41, row: 4'd12, pix: 8'hC3, expPix: 8'h00};
        vecs[2] = '{a: 8'h7F, b: 8'h20, row: 4'd9,  pix: 8'h99, expPix: 8'h99};
        vecs[3] = '{a: 8'h15, b: 8'h33, row: 4'd10, pix: 8'hF0, expPix: 8'h00};
        vecs[4] = '{a: 8'hAA, b: 8'h01, row: 4'd0,  pix: 8'h81, expPix: 8'h81};
        vecs[5] = '{a: 8'h01, b: 8'h7E, row: 4'd15, pix: 8'h55, expPix: 8'h00};

        rst = 1'b1;
        char_req = 1'b0; mbx_rd_req = 1'b0; mbx_wr_req = 1'b0; ve_n = 1'b1;
        char_a = 8'h00; char_b = 8'h00; char_row = 4'd0;
        mbx_wdata_a = 8'h00; mbx_wdata_b = 8'h00;
        gen_pix = 8'h00; gen_ta = 8'h00; gen_tb = 8'h00;
        setTiming(1'b0, 1, 4, 1);
        repeat (3) @(negedge clk);

        checkOutput("reset sm_n", 32'(sm_n_w[0]), 32'(1));
        checkOutput("reset sg_n", 32'(sg_n_w[0]), 32'(1));
        checkOutput("reset st_n", 32'(st_n_w[0]), 32'(1));
        checkOutput("reset r_wi", 32'(r_wi_w[0]), 32'(1));
        checkOutput("reset adr", 32'(adr_w[0]), 32'(0));
        checkOutput("reset busA_o", 32'(busA_o_w[0]), 32'(0));
        checkOutput("reset busB_o", 32'(busB_o_w[0]), 32'(0));
        checkOutput("reset pix_data", 32'(pix_data_w[0]), 32'(0));
        checkOutput("reset rdata_a", 32'(rdata_a_w[0]), 32'(0));
        checkOutput("reset rdata_b", 32'(rdata_b_w[0]), 32'(0));
        checkOutput("reset bus_oe", 32'(bus_oe_w[0]), 32'(0));
        checkOutput("reset busy", 32'(busy_w[0]), 32'(0));
        checkOutput("reset char_ack", 32'(char_ack_w[0]), 32'(0));
        checkOutput("reset pix_valid", 32'(pix_valid_w[0]), 32'(0));
        checkOutput("reset mbx_ack", 32'(mbx_ack_w[0]), 32'(0));
        checkOutput("reset mbx_pending", 32'(mbx_pending_w[0]), 32'(0));
        rst = 1'b0;

        ve_n = 1'b0;
        @(negedge clk);
        checkOutput("mbx_pending set", 32'(mbx_pending_w[0]), 32'(1));
        ve_n = 1'b1;
        @(negedge clk);
        checkOutput("mbx_pending clear", 32'(mbx_pending_w[0]), 32'(0));

        for (int v = 0; v < 6; v++) begin
            runChar(vecs[v].a, vecs[v].b, vecs[v].row, vecs[v].pix, vecs[v].expPix);
        end

        // Char and TYPE3 requested together: char wins, TYPE3 follows after one IDLE clock.
        mbx_rd_req = 1'b1;
        runChar(8'h00, 8'h41, 4'd3, 8'h3C, 8'h3C);
        runRd(8'hA5, 8'h5A);

        runWr(8'h12, 8'h34);

        // Reset during T2_ST aborts the fetch with no pix_valid.
        gen_pix = 8'h77;
        applyStimulus(0, 8'h00, 8'h41, 4'd3);
        for (int k = 1; k <= L + S + 1; k++) begin
            @(negedge clk);
            if (k == 1) char_req = 1'b0;
        end
        checkOutput("abort sg_n before reset", 32'(sg_n_w[0]), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort sm_n", 32'(sm_n_w[0]), 32'(1));
        checkOutput("abort sg_n", 32'(sg_n_w[0]), 32'(1));
        checkOutput("abort st_n", 32'(st_n_w[0]), 32'(1));
        checkOutput("abort bus_oe", 32'(bus_oe_w[0]), 32'(0));
        checkOutput("abort busy", 32'(busy_w[0]), 32'(0));
        checkOutput("abort pix_valid", 32'(pix_valid_w[0]), 32'(0));
        rst = 1'b0;
        for (int k = 1; k <= 2 * L + 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("post-abort pix_valid k%0d", k), 32'(pix_valid_w[0]), 32'(0));
            checkOutput($sformatf("post-abort busy k%0d", k), 32'(busy_w[0]), 32'(0));
        end
        runChar(8'h00, 8'h41, 4'd5, 8'h81, 8'h81);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] ra, rb, rp;
            logic [3:0] rr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 8'($urandom);
            rr = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: runChar(ra, rb, rr, rp, refPix(rr, rp));
                1: runRd(ra, rb);
                default: runWr(ra, rb);
            endcase
        end

        setTiming(1'b1, 2, 3, 2);
        runChar(vecs[0].a, vecs[0].b, vecs[0].row, vecs[0].pix, vecs[0].expPix);
        runChar(vecs[1].a, vecs[1].b, vecs[1].row, vecs[1].pix, vecs[1].expPix);
        runRd(8'hC6, 8'h39);
        runWr(8'h5E, 8'hE5);
        for (int n = 0; n < 6; n++) begin
            logic [7:0] ra, rb, rp;
            logic [3:0] rr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 8'($urandom);
            rr = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0: runChar(ra, rb, rr, rp, refPix(rr, rp));
                1: runRd(ra, rb);
                default: runWr(ra, rb);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
